// File: rtl/traffic_phase_scheduler.sv
// Timed two-road intersection scheduler: prescaled tick, min/max green, fixed yellow
// and all-red clearance, with sensor-driven arbitration between road A and road B.
module traffic_phase_scheduler #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sa,
    input  logic       sb,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic [2:0] phase,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    // tcnt also times yellow and all-red, so it must reach the largest of the three periods
    localparam int TMAX_A = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
    localparam int TMAX   = (TMAX_A > ALLRED_T) ? TMAX_A : ALLRED_T;
    localparam int TW     = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TCNT_SAT  = TW'(TMAX - 1);
    localparam logic [TW-1:0] MIN_M1    = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_M1    = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_M1    = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] CLR_M1    = TW'(ALLRED_T - 1);

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [2:0] {
        A_GREEN = 3'd0,
        A_YEL   = 3'd1,
        CLR_AB  = 3'd2,
        B_GREEN = 3'd3,
        B_YEL   = 3'd4,
        CLR_BA  = 3'd5
    } state_t;

    state_t        state_r;
    state_t        nxt_s;
    logic          adv_s;
    logic          tick_s;
    logic [PW-1:0] pcnt_r;
    logic [TW-1:0] tcnt_r;
    logic          sa_q1_r, sa_q2_r, sb_q1_r, sb_q2_r;
    logic          sa_s, sb_s;

    assign sa_s   = sa_q2_r;
    assign sb_s   = sb_q2_r;
    assign tick_s = (pcnt_r == PCNT_LAST);
    assign tick   = tick_s;
    assign phase  = state_r;

    // Next-state selection; transitions only fire in tick cycles, illegal codes recover at once
    always_comb begin
        nxt_s = state_r;
        adv_s = 1'b0;
        case (state_r)
            A_GREEN: begin
                if (tick_s && (tcnt_r >= MIN_M1) && sb_s && (!sa_s || (tcnt_r >= MAX_M1))) begin
                    nxt_s = A_YEL;
                    adv_s = 1'b1;
                end else begin
                    nxt_s = A_GREEN;
                    adv_s = 1'b0;
                end
            end
            A_YEL: begin
                if (tick_s && (tcnt_r == YEL_M1)) begin
                    nxt_s = CLR_AB;
                    adv_s = 1'b1;
                end else begin
                    nxt_s = A_YEL;
                    adv_s = 1'b0;
                end
            end
            CLR_AB: begin
                if (tick_s && (tcnt_r == CLR_M1)) begin
                    nxt_s = B_GREEN;
                    adv_s = 1'b1;
                end else begin
                    nxt_s = CLR_AB;
                    adv_s = 1'b0;
                end
            end
            B_GREEN: begin
                if (tick_s && (tcnt_r >= MIN_M1) && sa_s && (!sb_s || (tcnt_r >= MAX_M1))) begin
                    nxt_s = B_YEL;
                    adv_s = 1'b1;
                end else begin
                    nxt_s = B_GREEN;
                    adv_s = 1'b0;
                end
            end
            B_YEL: begin
                if (tick_s && (tcnt_r == YEL_M1)) begin
                    nxt_s = CLR_BA;
                    adv_s = 1'b1;
                end else begin
                    nxt_s = B_YEL;
                    adv_s = 1'b0;
                end
            end
            CLR_BA: begin
                if (tick_s && (tcnt_r == CLR_M1)) begin
                    nxt_s = A_GREEN;
                    adv_s = 1'b1;
                end else begin
                    nxt_s = CLR_BA;
                    adv_s = 1'b0;
                end
            end
            default: begin
                nxt_s = A_GREEN;
                adv_s = 1'b1;
            end
        endcase
    end

    // Sensor synchronisers, phase state, prescaler and phase timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa_q1_r <= 1'b0;
            sa_q2_r <= 1'b0;
            sb_q1_r <= 1'b0;
            sb_q2_r <= 1'b0;
            state_r <= A_GREEN;
            pcnt_r  <= '0;
            tcnt_r  <= '0;
        end else begin
            sa_q1_r <= sa;
            sa_q2_r <= sa_q1_r;
            sb_q1_r <= sb;
            sb_q2_r <= sb_q1_r;
            state_r <= nxt_s;
            if (adv_s) begin
                pcnt_r <= '0;
                tcnt_r <= '0;
            end else if (tick_s) begin
                pcnt_r <= '0;
                if (tcnt_r != TCNT_SAT) begin
                    tcnt_r <= tcnt_r + TW'(1);
                end else begin
                    tcnt_r <= tcnt_r;
                end
            end else begin
                pcnt_r <= pcnt_r + PW'(1);
                tcnt_r <= tcnt_r;
            end
        end
    end

    // Lamp codes decoded from the state register only
    always_comb begin
        la = RED;
        lb = RED;
        case (state_r)
            A_GREEN: begin la = GREEN;  lb = RED;    end
            A_YEL:   begin la = YELLOW; lb = RED;    end
            CLR_AB:  begin la = RED;    lb = RED;    end
            B_GREEN: begin la = RED;    lb = GREEN;  end
            B_YEL:   begin la = RED;    lb = YELLOW; end
            CLR_BA:  begin la = RED;    lb = RED;    end
            default: begin la = RED;    lb = RED;    end
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed and randomised checks of traffic_phase_scheduler with a short tick period.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       reset_n;
    logic       sa;
    logic       sb;
    logic [1:0] la;
    logic [1:0] lb;
    logic [2:0] phase;
    logic       tick;

    int checks;
    int errors;
    int cyc;

    traffic_phase_scheduler #(
        .TICK_DIV (4),
        .MIN_GREEN(2),
        .MAX_GREEN(4),
        .YELLOW_T (1),
        .ALLRED_T (1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sa     (sa),
        .sb     (sb),
        .la     (la),
        .lb     (lb),
        .phase  (phase),
        .tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [1:0] exp_la(input int ph);
        if (ph == 0) return 2'b00;
        else if (ph == 1) return 2'b01;
        else return 2'b10;
    endfunction

    function automatic logic [1:0] exp_lb(input int ph);
        if (ph == 3) return 2'b00;
        else if (ph == 4) return 2'b01;
        else return 2'b10;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic chk_phase(input string tag, input int ph);
        chk(tag, 32'(phase), 32'(ph));
        chk(tag, 32'(la), 32'(exp_la(ph)));
        chk(tag, 32'(lb), 32'(exp_lb(ph)));
    endtask

    initial begin
        int ph;
        int m;
        int prev_ph;
        int run_len;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        sa      = 1'b0;
        sb      = 1'b0;
        reset_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        chk("reset_phase", 32'(phase), 32'd0);
        chk("reset_la", 32'(la), 32'd0);
        chk("reset_lb", 32'(lb), 32'd2);
        chk("reset_tick", 32'(tick), 32'd0);

        // 1: only road B requesting
        sa = 1'b0;
        sb = 1'b1;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            ph = (c < 8) ? 0 : (c < 12) ? 1 : (c < 16) ? 2 : 3;
            chk_phase("s1_phase", ph);
            chk("s1_tick", 32'(tick), ((c % 4) == 3) ? 32'd1 : 32'd0);
            next_cyc();
        end

        // 2: both roads requesting, max-green alternation with 48-cycle period
        sa = 1'b1;
        sb = 1'b1;
        do_reset();
        for (int c = 0; c <= 100; c++) begin
            m  = c % 48;
            ph = (m < 16) ? 0 : (m < 20) ? 1 : (m < 24) ? 2 : (m < 40) ? 3 : (m < 44) ? 4 : 5;
            chk_phase("s2_phase", ph);
            next_cyc();
        end

        // 3: only road A requesting, green holds and timer saturates
        sa = 1'b1;
        sb = 1'b0;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            chk_phase("s3_hold", 0);
            next_cyc();
        end
        chk("s3_tcnt_sat", 32'(dut.tcnt_r), 32'd3);

        // 4: road B request arrives late while road A busy
        sa = 1'b1;
        sb = 1'b0;
        do_reset();
        while (cyc < 40) begin
            if (cyc == 9) sb = 1'b1;
            if (cyc == 29) sb = 1'b0;
            if (cyc == 15) chk_phase("s4_a_green_end", 0);
            if (cyc == 16) chk_phase("s4_a_yel", 1);
            if (cyc == 19) chk_phase("s4_a_yel_end", 1);
            if (cyc == 20) chk_phase("s4_clr_ab", 2);
            if (cyc == 24) chk_phase("s4_b_green", 3);
            if (cyc == 31) chk_phase("s4_b_green_end", 3);
            if (cyc == 32) chk_phase("s4_b_yel", 4);
            next_cyc();
        end

        // 5: asynchronous reset in the middle of A_YEL
        sa = 1'b0;
        sb = 1'b1;
        do_reset();
        while (cyc < 9) next_cyc();
        chk_phase("s5_pre_yel", 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s5_async_phase", 32'(phase), 32'd0);
        chk("s5_async_la", 32'(la), 32'd0);
        chk("s5_async_lb", 32'(lb), 32'd2);
        chk("s5_async_tick", 32'(tick), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        for (int c = 0; c <= 8; c++) begin
            chk_phase("s5_restart", (c < 8) ? 0 : 1);
            next_cyc();
        end

        // 6: random sensors, safety invariant and phase durations
        sa = 1'b0;
        sb = 1'b0;
        do_reset();
        prev_ph = 0;
        run_len = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 15) == 0) sa = ~sa;
            if ($urandom_range(0, 15) == 0) sb = ~sb;
            chk("s6_safety", ((la != 2'b10) && (lb != 2'b10)) ? 32'd1 : 32'd0, 32'd0);
            chk("s6_legal_phase", (phase >= 3'd6) ? 32'd1 : 32'd0, 32'd0);
            if (int'(phase) != prev_ph) begin
                if (prev_ph == 0 || prev_ph == 3)
                    chk("s6_green_min", (run_len >= 8) ? 32'd1 : 32'd0, 32'd1);
                else
                    chk("s6_yel_clr_len", 32'(run_len), 32'd4);
                prev_ph = int'(phase);
                run_len = 1;
            end else begin
                run_len++;
            end
            next_cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
